// File: rtl/morse_decoder.sv
// Morse letter decoder.
// A serial on/off Morse line is synchronized, timed in clock cycles, and split
// into dots and dashes. When the letter gap is seen, the collected symbols are
// looked up against International Morse A-Z. A valid letter produces a
// letter_valid pulse. An unknown or over-long pattern produces an err pulse.
// A line stuck high also produces an err pulse.
module morse_decoder #(
    parameter int TICK_CYCLES = 25000000
) (
    input  logic       CLOCK_50,
    input  logic       KEY,
    input  logic       morse_in,
    output logic [4:0] letter,
    output logic       letter_valid,
    output logic       err,
    output logic       busy,
    output logic [2:0] sym_count
);

    localparam int RUN_MAX_I = 8 * TICK_CYCLES;
    localparam int RUN_W     = $clog2(RUN_MAX_I + 1);

    // Run counter saturation point and the decision thresholds.
    // "Reaching" a threshold is detected one cycle early, when the counter
    // holds threshold-1, so the action coincides with the counter arriving.
    localparam logic [RUN_W-1:0] RUN_MAX    = RUN_W'(RUN_MAX_I);
    localparam logic [RUN_W-1:0] GLITCH_LIM = RUN_W'(TICK_CYCLES / 2);
    localparam logic [RUN_W-1:0] DASH_MIN   = RUN_W'(2 * TICK_CYCLES);
    localparam logic [RUN_W-1:0] GAP_LAST   = RUN_W'(2 * TICK_CYCLES - 1);
    localparam logic [RUN_W-1:0] STUCK_LAST = RUN_W'(8 * TICK_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        SPACE,
        DECODE,
        STUCK
    } state_t;

    state_t           state_reg;
    logic             sync_meta;
    logic             s_in;
    logic             s_prev;
    logic [RUN_W-1:0] run_reg;
    logic [3:0]       pattern_reg;
    logic             overflow_reg;

    logic             s_rise;
    logic             s_fall;
    logic             start_mark;
    logic [5:0]       lookup_res;

    assign s_rise     = s_in & ~s_prev;
    assign s_fall     = ~s_in & s_prev;
    assign start_mark = (state_reg == IDLE) && s_in;
    assign lookup_res = morse_lookup({sym_count, pattern_reg});

    // Returns {hit, letter_index} for a {symbol count, pattern} pair.
    // The pattern holds dot = 0 and dash = 1, with the first symbol in bit 3.
    function automatic logic [5:0] morse_lookup(input logic [6:0] key);
        logic [5:0] res;
        case (key)
            7'b010_0100: res = {1'b1, 5'd0};   // A .-
            7'b100_1000: res = {1'b1, 5'd1};   // B -...
            7'b100_1010: res = {1'b1, 5'd2};   // C -.-.
            7'b011_1000: res = {1'b1, 5'd3};   // D -..
            7'b001_0000: res = {1'b1, 5'd4};   // E .
            7'b100_0010: res = {1'b1, 5'd5};   // F ..-.
            7'b011_1100: res = {1'b1, 5'd6};   // G --.
            7'b100_0000: res = {1'b1, 5'd7};   // H ....
            7'b010_0000: res = {1'b1, 5'd8};   // I ..
            7'b100_0111: res = {1'b1, 5'd9};   // J .---
            7'b011_1010: res = {1'b1, 5'd10};  // K -.-
            7'b100_0100: res = {1'b1, 5'd11};  // L .-..
            7'b010_1100: res = {1'b1, 5'd12};  // M --
            7'b010_1000: res = {1'b1, 5'd13};  // N -.
            7'b011_1110: res = {1'b1, 5'd14};  // O ---
            7'b100_0110: res = {1'b1, 5'd15};  // P .--.
            7'b100_1101: res = {1'b1, 5'd16};  // Q --.-
            7'b011_0100: res = {1'b1, 5'd17};  // R .-.
            7'b011_0000: res = {1'b1, 5'd18};  // S ...
            7'b001_1000: res = {1'b1, 5'd19};  // T -
            7'b011_0010: res = {1'b1, 5'd20};  // U ..-
            7'b100_0001: res = {1'b1, 5'd21};  // V ...-
            7'b011_0110: res = {1'b1, 5'd22};  // W .--
            7'b100_1001: res = {1'b1, 5'd23};  // X -..-
            7'b100_1011: res = {1'b1, 5'd24};  // Y -.--
            7'b100_1100: res = {1'b1, 5'd25};  // Z --..
            default:     res = {1'b0, 5'd0};
        endcase
        return res;
    endfunction

    // Two-flop synchronizer plus one delayed copy for edge detection.
    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            sync_meta <= 1'b0;
            s_in      <= 1'b0;
            s_prev    <= 1'b0;
        end else begin
            sync_meta <= morse_in;
            s_in      <= sync_meta;
            s_prev    <= s_in;
        end
    end

    // Cycles since the last line change, restarted when a letter starts, saturating.
    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            run_reg <= '0;
        end else if (s_rise || s_fall || start_mark) begin
            run_reg <= '0;
        end else if (run_reg != RUN_MAX) begin
            run_reg <= run_reg + 1'b1;
        end
    end

    // Letter FSM with symbol storage and registered outputs.
    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            state_reg    <= IDLE;
            pattern_reg  <= 4'd0;
            overflow_reg <= 1'b0;
            sym_count    <= 3'd0;
            letter       <= 5'd0;
            letter_valid <= 1'b0;
            err          <= 1'b0;
            busy         <= 1'b0;
        end else begin
            letter_valid <= 1'b0;
            err          <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // A level test also catches a mark that began during DECODE.
                    if (s_in) begin
                        state_reg    <= MARK;
                        pattern_reg  <= 4'd0;
                        overflow_reg <= 1'b0;
                        sym_count    <= 3'd0;
                        busy         <= 1'b1;
                    end
                end
                MARK: begin
                    if (s_fall) begin
                        if (run_reg < GLITCH_LIM) begin
                            // Too short to be a symbol: ignore it.
                            if (sym_count != 3'd0) begin
                                state_reg <= SPACE;
                            end else begin
                                state_reg <= IDLE;
                                busy      <= 1'b0;
                            end
                        end else begin
                            if (sym_count == 3'd4) begin
                                overflow_reg <= 1'b1;
                            end else begin
                                pattern_reg[2'd3 - sym_count[1:0]] <= (run_reg >= DASH_MIN);
                                sym_count <= sym_count + 3'd1;
                            end
                            state_reg <= SPACE;
                        end
                    end else if (run_reg == STUCK_LAST) begin
                        state_reg <= STUCK;
                        err       <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                SPACE: begin
                    // The letter gap takes priority over a new mark in the same cycle.
                    if (run_reg == GAP_LAST) begin
                        state_reg <= DECODE;
                        busy      <= 1'b0;
                        if (lookup_res[5] && !overflow_reg) begin
                            letter       <= lookup_res[4:0];
                            letter_valid <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (s_rise) begin
                        state_reg <= MARK;
                    end
                end
                DECODE: begin
                    state_reg    <= IDLE;
                    pattern_reg  <= 4'd0;
                    overflow_reg <= 1'b0;
                    sym_count    <= 3'd0;
                end
                STUCK: begin
                    if (!s_in) begin
                        state_reg    <= IDLE;
                        pattern_reg  <= 4'd0;
                        overflow_reg <= 1'b0;
                        sym_count    <= 3'd0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morse_decoder.sv
// Directed testbench for morse_decoder with TICK_CYCLES = 10.
module tb_morse_decoder;

    logic       CLOCK_50;
    logic       KEY;
    logic       morse_in;
    logic [4:0] letter;
    logic       letter_valid;
    logic       err;
    logic       busy;
    logic [2:0] sym_count;

    int n_checks;
    int n_errors;

    // Activity seen by the monitor since the last clear.
    int         cyc;
    int         lv_count;
    int         err_count;
    int         both_count;
    int         lv_cyc;
    int         err_cyc;
    int         fall_cyc;
    int         rise_cyc;
    logic [4:0] first_letter;
    logic [4:0] second_letter;
    logic [2:0] prev_sym;
    logic [2:0] sym_before;
    logic [2:0] max_sym;

    morse_decoder #(.TICK_CYCLES(10)) dut (
        .CLOCK_50     (CLOCK_50),
        .KEY          (KEY),
        .morse_in     (morse_in),
        .letter       (letter),
        .letter_valid (letter_valid),
        .err          (err),
        .busy         (busy),
        .sym_count    (sym_count)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Sample outputs on the falling edge.
    always @(negedge CLOCK_50) begin
        if (letter_valid) begin
            if (lv_count == 0) first_letter = letter;
            else               second_letter = letter;
            lv_count   = lv_count + 1;
            lv_cyc     = cyc;
            sym_before = prev_sym;
        end
        if (err) begin
            err_count = err_count + 1;
            err_cyc   = cyc;
        end
        if (letter_valid && err) both_count = both_count + 1;
        if (sym_count > max_sym) max_sym = sym_count;
        prev_sym = sym_count;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        lv_count   = 0;
        err_count  = 0;
        lv_cyc     = -1;
        err_cyc    = -1;
        sym_before = 3'd0;
        max_sym    = 3'd0;
    endtask

    // Hold morse_in at v for n cycles; inputs change 1 time unit after a rising edge.
    task automatic drive(input logic v, input int n);
        if (v && !morse_in) rise_cyc = cyc;
        if (!v && morse_in) fall_cyc = cyc;
        morse_in = v;
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    // Send symbols with 10-cycle intra-letter gaps; the caller supplies the final gap.
    task automatic send(input string code);
        for (int i = 0; i < code.len(); i++) begin
            byte c;
            c = code[i];
            drive(1'b1, (c == 8'h2d) ? 30 : 10);
            if (i != code.len() - 1) drive(1'b0, 10);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        cyc        = 0;
        both_count = 0;
        prev_sym   = 3'd0;
        rise_cyc   = 0;
        fall_cyc   = 0;
        first_letter  = 5'd0;
        second_letter = 5'd0;
        clear_mon();
        KEY      = 1'b0;
        morse_in = 1'b0;
        repeat (4) @(posedge CLOCK_50);
        #1;
        check("rst_letter", 32'(letter), 0);
        check("rst_valid", 32'(letter_valid), 0);
        check("rst_err", 32'(err), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_sym", 32'(sym_count), 0);
        KEY = 1'b1;
        drive(1'b0, 5);
        $display("txn reset: letter=%0d busy=%0d", letter, busy);

        // A: latency and symbol count before the pulse.
        clear_mon();
        send(".-");
        drive(1'b0, 30);
        check("a_count", 32'(lv_count), 1);
        check("a_letter", 32'(first_letter), 0);
        check("a_latency", 32'(lv_cyc - fall_cyc), 23);
        check("a_sym", 32'(sym_before), 2);
        check("a_err", 32'(err_count), 0);
        check("a_busy", 32'(busy), 0);
        $display("txn A: letters=%0d letter=%0d latency=%0d", lv_count, first_letter, lv_cyc - fall_cyc);

        // T then E, with a gap that coincides with the decode point.
        clear_mon();
        drive(1'b1, 30);
        drive(1'b0, 20);
        drive(1'b1, 10);
        drive(1'b0, 30);
        check("te_count", 32'(lv_count), 2);
        check("te_first", 32'(first_letter), 19);
        check("te_second", 32'(second_letter), 4);
        $display("txn TE: letters=%0d first=%0d second=%0d", lv_count, first_letter, second_letter);

        // Five dots: overflow rejected, letter held at E.
        clear_mon();
        send(".....");
        drive(1'b0, 30);
        check("ovf_err", 32'(err_count), 1);
        check("ovf_valid", 32'(lv_count), 0);
        check("ovf_letter", 32'(letter), 4);
        check("ovf_maxsym", 32'(max_sym), 4);
        $display("txn overflow: errs=%0d letter=%0d", err_count, letter);

        // Glitch while idle.
        clear_mon();
        drive(1'b1, 3);
        drive(1'b0, 30);
        check("glitch_valid", 32'(lv_count), 0);
        check("glitch_err", 32'(err_count), 0);
        check("glitch_busy", 32'(busy), 0);
        check("glitch_sym", 32'(sym_count), 0);
        $display("txn idle glitch: letters=%0d errs=%0d", lv_count, err_count);

        // S with a short glitch between the first and second dot.
        clear_mon();
        drive(1'b1, 10);
        drive(1'b0, 4);
        drive(1'b1, 3);
        drive(1'b0, 4);
        drive(1'b1, 10);
        drive(1'b0, 10);
        drive(1'b1, 10);
        drive(1'b0, 30);
        check("s_count", 32'(lv_count), 1);
        check("s_letter", 32'(first_letter), 18);
        check("s_err", 32'(err_count), 0);
        $display("txn S glitch: letters=%0d letter=%0d", lv_count, first_letter);

        // Line stuck high for 100 cycles.
        clear_mon();
        drive(1'b1, 100);
        check("stuck_err", 32'(err_count), 1);
        check("stuck_when", 32'(err_cyc - rise_cyc), 83);
        check("stuck_busy", 32'(busy), 0);
        drive(1'b0, 30);
        check("stuck_valid", 32'(lv_count), 0);
        check("stuck_sym", 32'(sym_count), 0);
        clear_mon();
        send(".");
        drive(1'b0, 30);
        check("after_stuck", 32'(first_letter), 4);
        check("after_stuck_n", 32'(lv_count), 1);
        $display("txn stuck: err_at=%0d then letter=%0d", err_cyc, first_letter);

        // Reset in the middle of Q's first dash, then a clean Q.
        clear_mon();
        send("-");
        drive(1'b0, 10);
        drive(1'b1, 15);
        KEY      = 1'b0;
        morse_in = 1'b0;
        #1;
        check("mid_rst_letter", 32'(letter), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_sym", 32'(sym_count), 0);
        check("mid_rst_valid", 32'(letter_valid), 0);
        check("mid_rst_err", 32'(err), 0);
        repeat (4) @(posedge CLOCK_50);
        #1;
        KEY = 1'b1;
        drive(1'b0, 10);
        send("--.-");
        drive(1'b0, 30);
        check("q_count", 32'(lv_count), 1);
        check("q_letter", 32'(first_letter), 16);
        check("q_err", 32'(err_count), 0);
        $display("txn Q after reset: letters=%0d letter=%0d", lv_count, first_letter);

        check("valid_err_overlap", 32'(both_count), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
